// File: rtl/coef_block_sequencer_pkg.sv
// Shared types and constants for the coefficient block sequencer and its VLI decoder.
package coef_block_sequencer_pkg;

  localparam int TOK_RUN_W  = 4;
  localparam int TOK_SIZE_W = 4;
  localparam int TOK_BITS_W = 11;
  localparam int VLI_W      = 12;
  localparam int POS_W      = 6;

  localparam logic [TOK_SIZE_W-1:0] MAX_SIZE = 4'd11;
  localparam logic [TOK_RUN_W-1:0]  ZRL_RUN  = 4'd15;
  localparam logic [POS_W-1:0]      LAST_POS = 6'd63;

  localparam logic [2:0] S_DC   = 3'd0;
  localparam logic [2:0] S_AC   = 3'd1;
  localparam logic [2:0] S_ZERO = 3'd2;
  localparam logic [2:0] S_VAL  = 3'd3;
  localparam logic [2:0] S_FILL = 3'd4;

  typedef struct packed {
    logic [TOK_RUN_W-1:0]  run;
    logic [TOK_SIZE_W-1:0] size;
    logic [TOK_BITS_W-1:0] bits;
  } tok_t;

  // Stream order puts the first received bit in bit0; VLI wants it as the MSB.
  function automatic logic [TOK_BITS_W-1:0] bit_reverse(input logic [TOK_BITS_W-1:0] b);
    logic [TOK_BITS_W-1:0] r;
    for (int i = 0; i < TOK_BITS_W; i++) r[TOK_BITS_W-1-i] = b[i];
    return r;
  endfunction

endpackage

// File: rtl/coef_block_sequencer_vli_decoder.sv
// Combinational JPEG VLI decode: magnitude category + raw bits -> 12-bit signed value.
module vli_decoder
  import coef_block_sequencer_pkg::*;
(
  input  logic [TOK_SIZE_W-1:0] size,
  input  logic [TOK_BITS_W-1:0] bits,
  output logic signed [VLI_W-1:0] value,
  output logic                    bad_size
);

  logic [VLI_W-1:0] mag;

  // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
  always_comb begin
    value    = '0;
    mag      = '0;
    bad_size = (size > MAX_SIZE);
    if (!bad_size && size != '0) begin
      mag = {1'b0, bit_reverse(bits) >> (4'd11 - size)};
      // Leading 0 marks a negative value: v - (2^size - 1).
      if (mag[size - 4'd1]) value = $signed(mag);
      else                  value = $signed(mag - ((12'd1 << size) - 12'd1));
    end
  end

endmodule

// File: rtl/coef_block_sequencer.sv
// Expands Huffman tokens into 64 zigzag-ordered coefficients per block with DC prediction.
module coef_block_sequencer
  import coef_block_sequencer_pkg::*;
#(
  parameter int NUM_COMP = 4,
  parameter int COEF_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tok_valid,
  output logic                        tok_ready,
  input  logic [TOK_RUN_W-1:0]        tok_run,
  input  logic [TOK_SIZE_W-1:0]       tok_size,
  input  logic [TOK_BITS_W-1:0]       tok_bits,
  input  logic [$clog2(NUM_COMP)-1:0] tok_comp,
  input  logic                        dc_clear,
  output logic                        coef_valid,
  input  logic                        coef_ready,
  output logic signed [COEF_W-1:0]    coef_value,
  output logic [POS_W-1:0]            coef_idx,
  output logic                        coef_last,
  output logic                        err
);

  logic [2:0]               state;
  logic [POS_W-1:0]         pos;
  logic [4:0]               zcnt;
  logic                     held;
  logic signed [COEF_W-1:0] held_val;
  logic signed [COEF_W-1:0] pred [NUM_COMP];

  tok_t                     tok;
  logic signed [VLI_W-1:0]  vli_value;
  logic                     vli_bad;
  logic signed [COEF_W-1:0] diff;
  logic signed [COEF_W-1:0] dc_base;
  logic signed [COEF_W-1:0] dc_sum;
  logic                     out_free;
  logic                     tok_acc;
  logic                     at_end;

  assign tok = '{run: tok_run, size: tok_size, bits: tok_bits};

  vli_decoder u_vli_decoder (
    .size     (tok.size),
    .bits     (tok.bits),
    .value    (vli_value),
    .bad_size (vli_bad)
  );

  assign diff      = {{(COEF_W-VLI_W){vli_value[VLI_W-1]}}, vli_value};
  assign out_free  = !coef_valid || coef_ready;
  assign tok_ready = !rst && out_free && (state == S_DC || state == S_AC);
  assign tok_acc   = tok_valid && tok_ready;
  assign at_end    = (pos == LAST_POS);

  // A restart marker in the accept cycle means the DC token predicts from zero.
  assign dc_base = dc_clear ? '0 : pred[tok_comp];
  assign dc_sum  = dc_base + diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_DC;
      pos        <= '0;
      zcnt       <= '0;
      held       <= 1'b0;
      held_val   <= '0;
      coef_valid <= 1'b0;
      coef_value <= '0;
      coef_idx   <= '0;
      coef_last  <= 1'b0;
      err        <= 1'b0;
      // NOTE: the predictor array is architectural state (reset must zero it), so it is
      // reset explicitly here rather than left to whatever the storage powers up with.
      for (int c = 0; c < NUM_COMP; c++) pred[c] <= '0;
    end else begin
      err <= 1'b0;
      if (coef_ready) coef_valid <= 1'b0;

      for (int c = 0; c < NUM_COMP; c++) begin
        if (dc_clear) pred[c] <= '0;
      end

      if (out_free) begin
        case (state)
          S_DC: begin
            if (tok_acc) begin
              // NOTE: non-blocking updates resolve last-writer-wins, so this update
              // overrides the clear above for the addressed component.
              pred[tok_comp] <= dc_sum;
              coef_valid     <= 1'b1;
              coef_value     <= dc_sum;
              coef_idx       <= '0;
              coef_last      <= 1'b0;
              err            <= vli_bad;
              pos            <= 6'd1;
              state          <= S_AC;
            end
          end

          S_AC: begin
            if (tok_acc) begin
              err <= vli_bad;
              if (vli_bad || tok.size == '0) begin
                held <= 1'b0;
                if (tok.run == ZRL_RUN) begin
                  zcnt  <= 5'd16;
                  state <= S_ZERO;
                end else begin
                  state <= S_FILL;
                end
              end else begin
                held     <= 1'b1;
                held_val <= diff;
                zcnt     <= {1'b0, tok.run};
                state    <= (tok.run == '0) ? S_VAL : S_ZERO;
              end
            end
          end

          S_ZERO: begin
            coef_valid <= 1'b1;
            coef_value <= '0;
            coef_idx   <= pos;
            coef_last  <= at_end;
            if (at_end) begin
              // Anything still pending past position 63 is an overflow and is dropped.
              err   <= held || (zcnt != 5'd1);
              held  <= 1'b0;
              pos   <= '0;
              state <= S_DC;
            end else begin
              pos  <= pos + 6'd1;
              zcnt <= zcnt - 5'd1;
              if (zcnt == 5'd1) state <= held ? S_VAL : S_AC;
            end
          end

          S_VAL: begin
            coef_valid <= 1'b1;
            coef_value <= held_val;
            coef_idx   <= pos;
            coef_last  <= at_end;
            held       <= 1'b0;
            pos        <= at_end ? '0 : pos + 6'd1;
            state      <= at_end ? S_DC : S_AC;
          end

          S_FILL: begin
            coef_valid <= 1'b1;
            coef_value <= '0;
            coef_idx   <= pos;
            coef_last  <= at_end;
            pos        <= at_end ? '0 : pos + 6'd1;
            if (at_end) state <= S_DC;
          end

          default: state <= S_DC;
        endcase
      end
    end
  end

endmodule
